// File: rtl/data_memory_busywait.sv
// data_memory_busywait: multi-cycle byte memory with a read/write request and busywait stall handshake.
module data_memory_busywait #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ACCESS_CYCLES = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] writedata_i,
  output logic [DATA_W-1:0] readdata_o,
  output logic              busywait_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, readdata_q;
  logic op_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic valid_req, start, done_edge;
  assign valid_req = read_i ^ write_i;
  assign start = (state_q == IDLE) && valid_req;
  assign done_edge = (state_q == BUSY) && (cnt_q == 4'd0);
  assign busywait_o = !reset_i && (start || state_q == BUSY);
  assign readdata_o = readdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = valid_req ? BUSY : IDLE;
        cnt_d = valid_req ? LAST : cnt_q;
      end
      BUSY: begin
        state_d = done_edge ? DONE : BUSY;
        cnt_d = done_edge ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (start) begin
        addr_q <= address_i;
        data_q <= writedata_i;
        op_q <= write_i;
      end
      if (done_edge && !op_q) readdata_q <= mem[addr_q];
    end
  end
  // Array has no reset; a reset during an access simply suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && done_edge && op_q) mem[addr_q] <= data_q;
  end
endmodule

// File: tb/tb_data_memory_busywait.sv
// tb_data_memory_busywait: transaction-level checks of the stall handshake against a byte-array model.
module tb_data_memory_busywait;
  localparam int AC = 5;
  logic clk = 1'b0;
  logic reset_i, read_i, write_i;
  logic [7:0] address_i, writedata_i, readdata_o;
  logic busywait_o;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [256];
  bit known [256];
  logic [7:0] rd_m = 8'h00;
  logic [7:0] written [$];

  data_memory_busywait #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
    .clk_i(clk), .reset_i(reset_i), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .writedata_i(writedata_i),
    .readdata_o(readdata_o), .busywait_o(busywait_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle just after the edge; returns at mid-cycle of DONE with the request still held.
  task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    write_i = wr;
    read_i = !wr;
    address_i = a;
    writedata_i = d;
    @(negedge clk);
    while (busywait_o === 1'b1 && n < 40) begin
      n++;
      step();
      address_i = 8'($urandom);
      writedata_i = 8'($urandom);
      @(negedge clk);
    end
    check(wr ? "wr_busy_len" : "rd_busy_len", n, AC + 1);
    if (wr) begin
      mem_m[a] = d;
      if (!known[a]) written.push_back(a);
      known[a] = 1'b1;
    end else if (known[a]) begin
      rd_m = mem_m[a];
    end
    check(wr ? "rdata_after_wr" : "rdata_after_rd", readdata_o, rd_m);
  endtask

  initial begin
    reset_i = 1'b1;
    read_i = 1'b1;
    write_i = 1'b0;
    address_i = 8'h00;
    writedata_i = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("busy_in_reset", busywait_o, 1'b0);
    end
    step();
    reset_i = 1'b0;
    read_i = 1'b0;
    @(negedge clk);
    check("rdata_reset", readdata_o, 8'h00);
    check("busy_idle", busywait_o, 1'b0);

    step(); access(1'b1, 8'h05, 8'h3C);
    step(); access(1'b0, 8'h05, 8'h00);
    check("rd_05", readdata_o, 8'h3C);
    step(); access(1'b1, 8'hFF, 8'hAA);
    step(); access(1'b1, 8'h00, 8'h55);
    step(); access(1'b0, 8'hFF, 8'h00);
    check("rd_FF", readdata_o, 8'hAA);
    step(); access(1'b0, 8'h00, 8'h00);
    check("rd_00", readdata_o, 8'h55);
    step(); access(1'b0, 8'h05, 8'h00);
    check("rd_latched_addr", readdata_o, 8'h3C);

    // Reset on the third BUSY cycle of a write must leave the old byte in place.
    step(); access(1'b1, 8'h10, 8'h11);
    step();
    write_i = 1'b1; read_i = 1'b0; address_i = 8'h10; writedata_i = 8'h77;
    repeat (3) step();
    reset_i = 1'b1;
    @(negedge clk);
    check("busy_mid_reset", busywait_o, 1'b0);
    step();
    reset_i = 1'b0; write_i = 1'b0;
    rd_m = 8'h00;
    @(negedge clk);
    check("busy_after_abort", busywait_o, 1'b0);
    check("rdata_after_abort", readdata_o, 8'h00);
    step(); access(1'b0, 8'h10, 8'h00);
    check("rd_10_kept", readdata_o, 8'h11);

    step();
    read_i = 1'b1; write_i = 1'b1; address_i = 8'h05; writedata_i = 8'hE1;
    repeat (3) begin
      @(negedge clk);
      check("busy_illegal", busywait_o, 1'b0);
      check("rdata_illegal", readdata_o, 8'h11);
      step();
    end
    access(1'b0, 8'h05, 8'h00);
    check("mem_after_illegal", readdata_o, 8'h3C);
    // Request held across DONE: the next access must start fresh from IDLE.
    step(); access(1'b0, 8'hFF, 8'h00);
    step(); access(1'b0, 8'hFF, 8'h00);
    check("rd_FF_held", readdata_o, 8'hAA);

    for (int i = 0; i < 40; i++) begin
      logic wr;
      logic [7:0] a;
      wr = 1'($urandom);
      a = wr ? 8'($urandom) : written[$urandom_range(written.size() - 1)];
      if ($urandom_range(2) == 0) begin
        step();
        read_i = 1'b0; write_i = 1'b0;
        @(negedge clk);
        check("busy_gap", busywait_o, 1'b0);
      end
      step(); access(wr, a, 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
